// File: rtl/sap_pkg.sv
// Shared definitions for the microcode sequencer:
// opcodes, FSM states, control word and step counts.
package sap_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_LDIA = 5'h01;
  localparam logic [4:0] OP_LDIB = 5'h02;
  localparam logic [4:0] OP_LDA  = 5'h03;
  localparam logic [4:0] OP_LDB  = 5'h04;
  localparam logic [4:0] OP_STA  = 5'h05;
  localparam logic [4:0] OP_STB  = 5'h06;
  localparam logic [4:0] OP_ADD  = 5'h07;
  localparam logic [4:0] OP_SUB  = 5'h08;
  localparam logic [4:0] OP_OUTA = 5'h09;
  localparam logic [4:0] OP_OUTB = 5'h0A;
  localparam logic [4:0] OP_JMP  = 5'h0B;
  localparam logic [4:0] OP_JZ   = 5'h0C;
  localparam logic [4:0] OP_JC   = 5'h0D;
  localparam logic [4:0] OP_INC  = 5'h0E;
  localparam logic [4:0] OP_DEC  = 5'h0F;
  localparam logic [4:0] OP_HLT  = 5'h10;
  localparam logic [4:0] OP_CMP  = 5'h11;

  // index of the final execute step per class
  localparam int LAST_NOP = 0;
  localparam int LAST_LDI = 1;
  localparam int LAST_MEM = 2;
  localparam int LAST_ALU = 1;
  localparam int LAST_OUT = 1;
  localparam int LAST_JMP = 1;
  localparam int LAST_JNT = 0;
  localparam int LAST_HLT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_ADDR,
    S_FETCH_MEM,
    S_EXEC,
    S_HALT
  } state_t;

  typedef struct packed {
    logic pc_to_mar;
    logic ir_load;
    logic mar_load;
    logic ram_read;
    logic ram_write;
    logic out_bus;
    logic reg_load_a;
    logic reg_enable_a;
    logic reg_load_b;
    logic reg_enable_b;
    logic reg_load_o;
    logic alu_enable;
    logic sub;
    logic inc_a;
    logic dec_a;
    logic flag_load;
    logic pc_inc;
    logic pc_load;
  } ctrl_t;

endpackage

// File: rtl/step_counter.sv
// Execute-step counter with clear, advance and
// hold-on-wait, plus a last-step compare.
module step_counter #(
  parameter int STEP_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  input  logic                  hold,
  input  logic [STEP_WIDTH-1:0] last_step,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  is_last
);

  logic [STEP_WIDTH-1:0] cnt_q;

  // count up on advance unless a memory wait holds it
  always_ff @(posedge clk) begin
    if (reset || clear) cnt_q <= '0;
    else if (advance && !hold) cnt_q <= cnt_q + 1'b1;
  end

  assign step    = cnt_q;
  assign is_last = (cnt_q == last_step);

endmodule

// File: rtl/microcode_sequencer.sv
// Fetch/decode/execute control FSM driving every
// datapath control line of the SAP-style machine.
module microcode_sequencer
  import sap_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5,
  parameter int STEP_WIDTH   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    c,
  input  logic                    z,
  input  logic                    ram_ready,
  output logic                    pc_to_mar,
  output logic                    ir_load,
  output logic                    mar_load,
  output logic                    ram_read,
  output logic                    ram_write,
  output logic                    out_bus,
  output logic                    reg_load_a,
  output logic                    reg_enable_a,
  output logic                    reg_load_b,
  output logic                    reg_enable_b,
  output logic                    reg_load_o,
  output logic                    alu_enable,
  output logic                    sub,
  output logic                    inc_a,
  output logic                    dec_a,
  output logic                    flag_load,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic [STEP_WIDTH-1:0]   step,
  output logic                    halted,
  output logic                    illegal
);

  state_t                  state_q, state_d;
  logic                    halted_q, illegal_q;
  logic                    take_q, take;
  logic [OPCODE_WIDTH-1:0] op_q, op_eff;
  logic [4:0]              op5;
  logic                    known, first;
  logic                    s0, s1, s2;
  logic                    set_halt, set_ill;
  logic                    waiting, adv, clr;
  logic [STEP_WIDTH-1:0]   step_q, last_idx;
  logic                    is_last;
  ctrl_t                   cw;

  step_counter #(.STEP_WIDTH(STEP_WIDTH)) u_step (
    .clk       (clk),
    .reset     (reset),
    .clear     (clr),
    .advance   (adv),
    .hold      (waiting),
    .last_step (last_idx),
    .step      (step_q),
    .is_last   (is_last)
  );

  // IR is live at s0; later steps use the copy
  // taken at s0, including the jump decision
  always_comb begin
    first  = (state_q == S_EXEC) && (step_q == '0);
    op_eff = first ? opcode : op_q;
    op5    = op_eff[4:0];
    known  = (op_eff == OPCODE_WIDTH'(op5));
    take   = take_q;
    if (first) take = (op5 == OP_JZ) ? z : c;
    s0 = (step_q == STEP_WIDTH'(0));
    s1 = (step_q == STEP_WIDTH'(1));
    s2 = (step_q == STEP_WIDTH'(2));
  end

  // control word decode from state, step and opcode
  always_comb begin
    cw       = '0;
    last_idx = STEP_WIDTH'(LAST_NOP);
    set_halt = 1'b0;
    set_ill  = 1'b0;
    unique case (state_q)
      S_FETCH_ADDR: cw.pc_to_mar = 1'b1;
      S_FETCH_MEM: begin
        cw.ram_read = 1'b1;
        cw.ir_load  = ram_ready;
      end
      S_EXEC: begin
        if (!known) set_ill = 1'b1;
        else case (op5)
          OP_NOP: cw.pc_inc = s0;
          OP_LDIA, OP_LDIB: begin
            cw.out_bus    = s0;
            cw.reg_load_a = s0 && (op5 == OP_LDIA);
            cw.reg_load_b = s0 && (op5 == OP_LDIB);
            cw.pc_inc     = s1;
            last_idx      = STEP_WIDTH'(LAST_LDI);
          end
          OP_LDA, OP_LDB: begin
            cw.mar_load   = s0;
            cw.out_bus    = s1;
            cw.ram_read   = s1;
            cw.reg_load_a = s2 && (op5 == OP_LDA);
            cw.reg_load_b = s2 && (op5 == OP_LDB);
            cw.pc_inc     = s2;
            last_idx      = STEP_WIDTH'(LAST_MEM);
          end
          OP_STA, OP_STB: begin
            cw.mar_load     = s0;
            cw.out_bus      = s1;
            cw.reg_enable_a = s2 && (op5 == OP_STA);
            cw.reg_enable_b = s2 && (op5 == OP_STB);
            cw.ram_write    = s2;
            // one increment only, on the completing cycle
            cw.pc_inc       = s2 && ram_ready;
            last_idx        = STEP_WIDTH'(LAST_MEM);
          end
          OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            cw.alu_enable = s0;
            cw.reg_load_a = s0;
            cw.flag_load  = s0;
            cw.sub        = s0 && (op5 == OP_SUB);
            cw.inc_a      = s0 && (op5 == OP_INC);
            cw.dec_a      = s0 && (op5 == OP_DEC);
            cw.pc_inc     = s1;
            last_idx      = STEP_WIDTH'(LAST_ALU);
          end
          OP_OUTA, OP_OUTB: begin
            cw.reg_enable_a = s0 && (op5 == OP_OUTA);
            cw.reg_enable_b = s0 && (op5 == OP_OUTB);
            cw.reg_load_o   = s0;
            cw.pc_inc       = s1;
            last_idx        = STEP_WIDTH'(LAST_OUT);
          end
          OP_JMP: begin
            cw.out_bus = s0;
            cw.pc_load = s0;
            last_idx   = STEP_WIDTH'(LAST_JMP);
          end
          OP_JZ, OP_JC: begin
            if (take) begin
              cw.out_bus = s0;
              cw.pc_load = s0;
              last_idx   = STEP_WIDTH'(LAST_JMP);
            end else begin
              cw.pc_inc = s0;
              last_idx  = STEP_WIDTH'(LAST_JNT);
            end
          end
          OP_HLT: begin
            set_halt = 1'b1;
            last_idx = STEP_WIDTH'(LAST_HLT);
          end
          OP_CMP: begin
            cw.alu_enable = s0;
            cw.sub        = s0;
            cw.flag_load  = s0;
            cw.pc_inc     = s1;
            last_idx      = STEP_WIDTH'(LAST_ALU);
          end
          default: set_ill = 1'b1;
        endcase
      end
      default: ;
    endcase
    // reset kills the in-flight write at its own edge
    if (reset) cw = '0;
  end

  // next state and step sequencing
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    clr     = 1'b0;
    waiting = (cw.ram_read || cw.ram_write) && !ram_ready;
    unique case (state_q)
      S_IDLE:       if (run) state_d = S_FETCH_ADDR;
      S_FETCH_ADDR: state_d = S_FETCH_MEM;
      S_FETCH_MEM:  if (ram_ready) state_d = S_EXEC;
      S_EXEC: begin
        if (set_halt || set_ill) state_d = S_HALT;
        else if (!waiting) begin
          if (is_last) begin
            state_d = S_FETCH_ADDR;
            clr     = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // state, sticky flags and s0 instruction latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= '0;
      take_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_halt) halted_q <= 1'b1;
      if (set_ill) illegal_q <= 1'b1;
      if (first) begin
        op_q   <= opcode;
        take_q <= take;
      end
    end
  end

  assign pc_to_mar    = cw.pc_to_mar;
  assign ir_load      = cw.ir_load;
  assign mar_load     = cw.mar_load;
  assign ram_read     = cw.ram_read;
  assign ram_write    = cw.ram_write;
  assign out_bus      = cw.out_bus;
  assign reg_load_a   = cw.reg_load_a;
  assign reg_enable_a = cw.reg_enable_a;
  assign reg_load_b   = cw.reg_load_b;
  assign reg_enable_b = cw.reg_enable_b;
  assign reg_load_o   = cw.reg_load_o;
  assign alu_enable   = cw.alu_enable;
  assign sub          = cw.sub;
  assign inc_a        = cw.inc_a;
  assign dec_a        = cw.dec_a;
  assign flag_load    = cw.flag_load;
  assign pc_inc       = cw.pc_inc;
  assign pc_load      = cw.pc_load;
  assign step         = step_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench: per-cycle expected control words
// are queued with their stimulus, then replayed.
module tb_microcode_sequencer;
  import sap_pkg::*;

  localparam logic [17:0] PC_TO_MAR = 18'h20000;
  localparam logic [17:0] IR_LOAD   = 18'h10000;
  localparam logic [17:0] MAR_LOAD  = 18'h08000;
  localparam logic [17:0] RAM_READ  = 18'h04000;
  localparam logic [17:0] RAM_WRITE = 18'h02000;
  localparam logic [17:0] OUT_BUS   = 18'h01000;
  localparam logic [17:0] LD_A      = 18'h00800;
  localparam logic [17:0] EN_A      = 18'h00400;
  localparam logic [17:0] LD_B      = 18'h00200;
  localparam logic [17:0] EN_B      = 18'h00100;
  localparam logic [17:0] LD_O      = 18'h00080;
  localparam logic [17:0] ALU       = 18'h00040;
  localparam logic [17:0] SUBM      = 18'h00020;
  localparam logic [17:0] INCM      = 18'h00010;
  localparam logic [17:0] DECM      = 18'h00008;
  localparam logic [17:0] FLAG      = 18'h00004;
  localparam logic [17:0] PC_INC    = 18'h00002;
  localparam logic [17:0] PC_LOAD   = 18'h00001;

  logic clk = 1'b0;
  logic reset = 1'b1, run = 1'b0;
  logic c = 1'b0, z = 1'b0, ram_ready = 1'b1;
  logic [4:0] opcode = 5'h0;
  logic pc_to_mar, ir_load, mar_load, ram_read;
  logic ram_write, out_bus, reg_load_a, reg_enable_a;
  logic reg_load_b, reg_enable_b, reg_load_o;
  logic alu_enable, sub, inc_a, dec_a, flag_load;
  logic pc_inc, pc_load, halted, illegal;
  logic [1:0] step;

  always #5 clk = ~clk;

  microcode_sequencer #(
    .OPCODE_WIDTH(5), .STEP_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .opcode(opcode), .c(c), .z(z),
    .ram_ready(ram_ready),
    .pc_to_mar(pc_to_mar), .ir_load(ir_load),
    .mar_load(mar_load), .ram_read(ram_read),
    .ram_write(ram_write), .out_bus(out_bus),
    .reg_load_a(reg_load_a),
    .reg_enable_a(reg_enable_a),
    .reg_load_b(reg_load_b),
    .reg_enable_b(reg_enable_b),
    .reg_load_o(reg_load_o),
    .alu_enable(alu_enable), .sub(sub),
    .inc_a(inc_a), .dec_a(dec_a),
    .flag_load(flag_load),
    .pc_inc(pc_inc), .pc_load(pc_load),
    .step(step), .halted(halted),
    .illegal(illegal)
  );

  typedef struct {
    logic [17:0] cw;
    logic [1:0]  st;
    logic        hl, il, rr, z, c, rst, run;
    logic [4:0]  op;
    logic [7:0]  bus;
  } ent_t;

  ent_t sb[$];
  int checks = 0;
  int errors = 0;
  string tag = "init";

  logic       cur_z = 0, cur_c = 0, cur_rst = 0;
  logic       cur_run = 0, exp_hl = 0, exp_il = 0;
  logic [4:0] cur_op = 0;
  logic [7:0] cur_bus = 0, bus_val = 0;

  // tiny datapath model driven by the DUT controls
  logic [7:0] a_m = 0, b_m = 0, o_m = 0;
  int wr_cnt = 0, lda_cnt = 0;

  function automatic logic [7:0] alu_f(
    input logic [7:0] a, input logic [7:0] b,
    input logic s, input logic i, input logic d);
    if (s) return a - b;
    if (i) return a + 8'd1;
    if (d) return a - 8'd1;
    return a + b;
  endfunction

  always @(posedge clk) begin
    if (reg_load_a)
      a_m <= alu_enable ?
        alu_f(a_m, b_m, sub, inc_a, dec_a) : bus_val;
    if (reg_load_b) b_m <= bus_val;
    if (reg_load_o) o_m <= reg_enable_a ? a_m : b_m;
    if (ram_write && ram_ready) wr_cnt <= wr_cnt + 1;
    if (reg_load_a) lda_cnt <= lda_cnt + 1;
  end

  // the step counter never reaches its top value
  always @(negedge clk) begin
    #2;
    checks++;
    if (step === 2'b11) begin
      errors++;
      $display("FAIL step_wrap: step=%0d, must stay below 3",
               step);
    end
  end

  task automatic push(input logic [17:0] cw,
                      input logic [1:0] st,
                      input logic rr);
    ent_t e;
    e.cw = cw; e.st = st; e.rr = rr;
    e.hl = exp_hl; e.il = exp_il;
    e.z = cur_z; e.c = cur_c;
    e.rst = cur_rst; e.run = cur_run;
    e.op = cur_op; e.bus = cur_bus;
    sb.push_back(e);
  endtask

  task automatic drain();
    ent_t e;
    logic [17:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; run = e.run;
      opcode = e.op; ram_ready = e.rr;
      z = e.z; c = e.c; bus_val = e.bus;
      #1;
      act = {pc_to_mar, ir_load, mar_load, ram_read,
             ram_write, out_bus, reg_load_a,
             reg_enable_a, reg_load_b, reg_enable_b,
             reg_load_o, alu_enable, sub, inc_a, dec_a,
             flag_load, pc_inc, pc_load};
      checks++;
      if (act !== e.cw || step !== e.st ||
          halted !== e.hl || illegal !== e.il) begin
        errors++;
        $display("FAIL %s: ctrl=%h step=%0d hl=%b il=%b, expected ctrl=%h step=%0d hl=%b il=%b",
                 tag, act, step, halted, illegal,
                 e.cw, e.st, e.hl, e.il);
      end
    end
  endtask

  task automatic push_instr(input logic [4:0] op,
                            input logic flag,
                            input int waits,
                            input logic [7:0] bus);
    logic [17:0] ld, en;
    cur_op = op; cur_bus = bus;
    cur_z = 0; cur_c = 0;
    push(PC_TO_MAR, 0, 1);
    push(RAM_READ | IR_LOAD, 0, 1);
    ld = (op == 5'h03) ? LD_A : LD_B;
    en = (op == 5'h05) ? EN_A : EN_B;
    case (op)
      5'h00: push(PC_INC, 0, 1);
      5'h01: begin
        push(OUT_BUS | LD_A, 0, 1); push(PC_INC, 1, 1);
      end
      5'h02: begin
        push(OUT_BUS | LD_B, 0, 1); push(PC_INC, 1, 1);
      end
      5'h03, 5'h04: begin
        push(MAR_LOAD, 0, 1);
        repeat (waits) push(OUT_BUS | RAM_READ, 1, 0);
        push(OUT_BUS | RAM_READ, 1, 1);
        push(ld | PC_INC, 2, 1);
      end
      5'h05, 5'h06: begin
        push(MAR_LOAD, 0, 1);
        push(OUT_BUS, 1, 1);
        repeat (waits) push(en | RAM_WRITE, 2, 0);
        push(en | RAM_WRITE | PC_INC, 2, 1);
      end
      5'h07, 5'h08, 5'h0E, 5'h0F: begin
        push(ALU | LD_A | FLAG |
             ((op == 5'h08) ? SUBM : 18'h0) |
             ((op == 5'h0E) ? INCM : 18'h0) |
             ((op == 5'h0F) ? DECM : 18'h0), 0, 1);
        push(PC_INC, 1, 1);
      end
      5'h09: begin
        push(EN_A | LD_O, 0, 1); push(PC_INC, 1, 1);
      end
      5'h0A: begin
        push(EN_B | LD_O, 0, 1); push(PC_INC, 1, 1);
      end
      5'h0B: begin
        push(OUT_BUS | PC_LOAD, 0, 1); push(18'h0, 1, 1);
      end
      5'h0C, 5'h0D: begin
        if (op == 5'h0C) cur_z = flag; else cur_c = flag;
        if (flag) begin
          push(OUT_BUS | PC_LOAD, 0, 1);
          cur_z = ~cur_z; cur_c = ~cur_c;
          push(18'h0, 1, 1);
        end else begin
          push(PC_INC, 0, 1);
        end
        cur_z = 0; cur_c = 0;
      end
      5'h10: begin push(18'h0, 0, 1); exp_hl = 1; end
      5'h11: begin
        push(ALU | SUBM | FLAG, 0, 1);
        push(PC_INC, 1, 1);
      end
      default: begin push(18'h0, 0, 1); exp_il = 1; end
    endcase
  endtask

  task automatic push_halted(input int n);
    for (int i = 0; i < n; i++) begin
      cur_run = i[0];
      push(18'h0, 0, 1);
    end
    cur_run = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; run = 0;
    cur_rst = 1; cur_run = 0; cur_op = 0;
    exp_hl = 0; exp_il = 0;
    push(18'h0, 0, 1);
    drain();
    cur_rst = 0;
  endtask

  task automatic start_run();
    cur_run = 1;
    push(18'h0, 0, 1);
    cur_run = 0;
  endtask

  task automatic check_state(input state_t s);
    checks++;
    if (dut.state_q !== s) begin
      errors++;
      $display("FAIL %s state: got %0d, expected %0d",
               tag, dut.state_q, s);
    end
  endtask

  task automatic test_reset();
    tag = "reset";
    do_reset();
    push(18'h0, 0, 1);
    push(18'h0, 0, 1);
    drain();
    check_state(S_IDLE);
  endtask

  task automatic test_program();
    tag = "program";
    do_reset();
    start_run();
    push_instr(5'h01, 0, 0, 8'd5);
    push_instr(5'h02, 0, 0, 8'd3);
    push_instr(5'h07, 0, 0, 8'd0);
    push_instr(5'h09, 0, 0, 8'd0);
    push_instr(5'h10, 0, 0, 8'd0);
    push_halted(3);
    drain();
    check_state(S_HALT);
    checks++;
    if (o_m !== 8'd8) begin
      errors++;
      $display("FAIL program out: got %0d, expected 8",
               o_m);
    end
  endtask

  task automatic test_mem_wait();
    int l0, w0;
    tag = "mem_wait";
    do_reset();
    start_run();
    l0 = lda_cnt;
    push_instr(5'h03, 0, 3, 8'd7);
    push_instr(5'h00, 0, 0, 8'd0);
    drain();
    checks++;
    if (lda_cnt - l0 !== 1 || a_m !== 8'd7) begin
      errors++;
      $display("FAIL ld_wait: loads=%0d a=%0d, expected 1 and 7",
               lda_cnt - l0, a_m);
    end
    w0 = wr_cnt;
    push_instr(5'h05, 0, 0, 8'd0);
    push_instr(5'h06, 0, 2, 8'd0);
    push_instr(5'h00, 0, 0, 8'd0);
    drain();
    checks++;
    if (wr_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL st_wait: writes=%0d, expected 2",
               wr_cnt - w0);
    end
  endtask

  task automatic test_jumps();
    tag = "jumps";
    do_reset();
    start_run();
    push_instr(5'h0C, 1, 0, 8'd0);
    push_instr(5'h0C, 0, 0, 8'd0);
    push_instr(5'h0D, 1, 0, 8'd0);
    push_instr(5'h0D, 0, 0, 8'd0);
    push_instr(5'h0B, 0, 0, 8'd0);
    push_instr(5'h00, 0, 0, 8'd0);
    drain();
  endtask

  task automatic test_illegal();
    tag = "illegal";
    do_reset();
    start_run();
    push_instr(5'h1F, 0, 0, 8'd0);
    push_halted(4);
    drain();
    check_state(S_HALT);
  endtask

  task automatic test_reset_mid_st();
    int w0;
    tag = "reset_mid_st";
    do_reset();
    start_run();
    w0 = wr_cnt;
    cur_op = 5'h05;
    push(PC_TO_MAR, 0, 1);
    push(RAM_READ | IR_LOAD, 0, 1);
    push(MAR_LOAD, 0, 1);
    push(OUT_BUS, 1, 1);
    cur_rst = 1;
    push(18'h0, 2, 1);
    cur_rst = 0;
    push(18'h0, 0, 1);
    push(18'h0, 0, 1);
    drain();
    check_state(S_IDLE);
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL reset_write: writes=%0d, expected 0",
               wr_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    tag = "back_to_back";
    do_reset();
    start_run();
    push_instr(5'h11, 0, 0, 8'd0);
    push_instr(5'h0E, 0, 0, 8'd0);
    push_instr(5'h0F, 0, 0, 8'd0);
    push_instr(5'h08, 0, 0, 8'd0);
    push_instr(5'h02, 0, 0, 8'd9);
    push_instr(5'h0A, 0, 0, 8'd0);
    push_instr(5'h04, 0, 1, 8'd4);
    push_instr(5'h06, 0, 0, 8'd0);
    push_instr(5'h00, 0, 0, 8'd0);
    push_instr(5'h10, 0, 0, 8'd0);
    push_halted(2);
    drain();
    check_state(S_HALT);
    checks++;
    if (o_m !== 8'd9 || b_m !== 8'd4) begin
      errors++;
      $display("FAIL b2b regs: out=%0d b=%0d, expected 9 and 4",
               o_m, b_m);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_mem_wait();
    test_jumps();
    test_illegal();
    test_reset_mid_st();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
